// File: rtl/node_ni_if.sv
// Signal bundle between node_ni, its processing element and router port 5.
//
// Handshake semantics: pe_valid/pe_ready and rx_valid/rx_ready transfer one
// flit at every rising edge where both are 1; a valid must hold its flit
// until it is taken. eject_valid and inject_valid cannot be back-pressured,
// and credit is a one-cycle pulse per freed router buffer slot.
interface node_ni_if #(
  parameter int FLIT_W = 20,
  parameter int POS_W  = 4
);
  localparam int PAY_W = FLIT_W - 2 * POS_W;

  logic [POS_W-1:0]  pe_dest;
  logic [PAY_W-1:0]  pe_payload;
  logic              pe_valid;
  logic              pe_ready;
  logic [FLIT_W-1:0] inject;
  logic              inject_valid;
  logic              credit;
  logic [FLIT_W-1:0] eject;
  logic              eject_valid;
  logic [FLIT_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  // NI side
  modport slave (
    input  pe_dest, pe_payload, pe_valid, credit, eject, eject_valid, rx_ready,
    output pe_ready, inject, inject_valid, rx_data, rx_valid
  );

  // PE / router side
  modport master (
    output pe_dest, pe_payload, pe_valid, credit, eject, eject_valid, rx_ready,
    input  pe_ready, inject, inject_valid, rx_data, rx_valid
  );
endinterface

// File: rtl/node_ni.sv
// Network interface between a PE and the local port of a mesh router:
// credit-metered injection FIFO with source stamping, and a dropping
// ejection FIFO for traffic the router cannot hold back.
module node_ni #(
  parameter int FLIT_W    = 20,
  parameter int POS_W     = 4,
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int CREDITS   = 4,
  localparam int CNT_W    = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [POS_W-1:0] position,
  node_ni_if.slave         bus,
  output logic [CNT_W-1:0] credit_cnt,
  output logic [7:0]       drop_cnt,
  output logic             overflow,
  output logic             credit_err
);
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);

  // Injection side state
  logic [FLIT_W-1:0] inj_mem_q [INJ_DEPTH];
  logic [FLIT_W-1:0] inj_mem_d [INJ_DEPTH];
  logic [IAW:0]      inj_wr_q, inj_wr_d;
  logic [IAW:0]      inj_rd_q, inj_rd_d;
  logic [FLIT_W-1:0] inject_q, inject_d;
  logic              inject_valid_q, inject_valid_d;
  logic [CNT_W-1:0]  credit_cnt_q, credit_cnt_d;
  logic              credit_err_q, credit_err_d;

  // Ejection side state
  logic [FLIT_W-1:0] ej_mem_q [EJ_DEPTH];
  logic [FLIT_W-1:0] ej_mem_d [EJ_DEPTH];
  logic [EAW:0]      ej_wr_q, ej_wr_d;
  logic [EAW:0]      ej_rd_q, ej_rd_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic inj_empty, inj_full, pe_push, send;
  logic ej_empty, ej_full, ej_pop, ej_push, ej_drop;
  logic credit_at_max;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign inj_empty = (inj_wr_q == inj_rd_q);
  assign inj_full  = (inj_wr_q[IAW] != inj_rd_q[IAW]) &&
                     (inj_wr_q[IAW-1:0] == inj_rd_q[IAW-1:0]);
  assign ej_empty  = (ej_wr_q == ej_rd_q);
  assign ej_full   = (ej_wr_q[EAW] != ej_rd_q[EAW]) &&
                     (ej_wr_q[EAW-1:0] == ej_rd_q[EAW-1:0]);

  // pe_ready comes from registered full state only; reset masks it.
  assign bus.pe_ready = !inj_full && !RST;
  assign pe_push      = bus.pe_valid && bus.pe_ready;
  assign send         = !inj_empty && (credit_cnt_q != '0);
  assign credit_at_max = (credit_cnt_q == CNT_W'(CREDITS));

  // Show-ahead ejection head; a pop frees room for a same-cycle push.
  assign bus.rx_valid = !ej_empty;
  assign bus.rx_data  = ej_mem_q[ej_rd_q[EAW-1:0]];
  assign ej_pop       = bus.rx_valid && bus.rx_ready;
  assign ej_push      = bus.eject_valid && (!ej_full || ej_pop);
  assign ej_drop      = bus.eject_valid && !ej_push;

  assign bus.inject       = inject_q;
  assign bus.inject_valid = inject_valid_q;
  assign credit_cnt       = credit_cnt_q;
  assign drop_cnt         = drop_cnt_q;
  assign overflow         = overflow_q;
  assign credit_err       = credit_err_q;

  // Injection FIFO write/stamp and credit-gated pop into the inject register.
  always_comb begin
    inj_mem_d      = inj_mem_q;
    inj_wr_d       = inj_wr_q;
    inj_rd_d       = inj_rd_q;
    inject_d       = inject_q;
    inject_valid_d = send;
    if (pe_push) begin
      inj_mem_d[inj_wr_q[IAW-1:0]] = {bus.pe_dest, position, bus.pe_payload};
      inj_wr_d = inj_wr_q + (IAW+1)'(1);
    end
    if (send) begin
      inject_d = inj_mem_q[inj_rd_q[IAW-1:0]];
      inj_rd_d = inj_rd_q + (IAW+1)'(1);
    end
  end

  // Credit counter: a send and a returned credit in one cycle cancel out.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (bus.credit && credit_at_max) begin
      credit_err_d = 1'b1;
    end
    if (bus.credit && !send) begin
      if (!credit_at_max) begin
        credit_cnt_d = credit_cnt_q + CNT_W'(1);
      end
    end else if (send && !bus.credit) begin
      credit_cnt_d = credit_cnt_q - CNT_W'(1);
    end
  end

  // Ejection FIFO push/pop and saturating drop accounting.
  always_comb begin
    ej_mem_d   = ej_mem_q;
    ej_wr_d    = ej_wr_q;
    ej_rd_d    = ej_rd_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (ej_push) begin
      ej_mem_d[ej_wr_q[EAW-1:0]] = bus.eject;
      ej_wr_d = ej_wr_q + (EAW+1)'(1);
    end
    if (ej_pop) begin
      ej_rd_d = ej_rd_q + (EAW+1)'(1);
    end
    if (ej_drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // State register; reset empties both FIFOs and clears their storage.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < INJ_DEPTH; i++) inj_mem_q[i] <= '0;
      for (int i = 0; i < EJ_DEPTH; i++)  ej_mem_q[i]  <= '0;
      inj_wr_q       <= '0;
      inj_rd_q       <= '0;
      inject_q       <= '0;
      inject_valid_q <= 1'b0;
      credit_cnt_q   <= CNT_W'(CREDITS);
      credit_err_q   <= 1'b0;
      ej_wr_q        <= '0;
      ej_rd_q        <= '0;
      drop_cnt_q     <= '0;
      overflow_q     <= 1'b0;
    end else begin
      inj_mem_q      <= inj_mem_d;
      ej_mem_q       <= ej_mem_d;
      inj_wr_q       <= inj_wr_d;
      inj_rd_q       <= inj_rd_d;
      inject_q       <= inject_d;
      inject_valid_q <= inject_valid_d;
      credit_cnt_q   <= credit_cnt_d;
      credit_err_q   <= credit_err_d;
      ej_wr_q        <= ej_wr_d;
      ej_rd_q        <= ej_rd_d;
      drop_cnt_q     <= drop_cnt_d;
      overflow_q     <= overflow_d;
    end
  end
endmodule

// File: tb/tb_node_ni.sv
// Self-checking bench for node_ni: cycle table, hand sequences for the
// ejection/credit/reset corners, then random traffic against queue models.
module tb_node_ni;
  localparam int FLIT_W    = 20;
  localparam int POS_W     = 4;
  localparam int INJ_DEPTH = 4;
  localparam int EJ_DEPTH  = 4;
  localparam int CREDITS   = 4;
  localparam int PAY_W     = FLIT_W - 2 * POS_W;
  localparam int CNT_W     = $clog2(CREDITS + 1);

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic [POS_W-1:0] position = '0;
  logic [CNT_W-1:0] credit_cnt;
  logic [7:0]       drop_cnt;
  logic             overflow, credit_err;

  always #5 clk = ~clk;

  node_ni_if #(.FLIT_W(FLIT_W), .POS_W(POS_W)) bus ();

  node_ni #(
    .FLIT_W(FLIT_W), .POS_W(POS_W), .INJ_DEPTH(INJ_DEPTH),
    .EJ_DEPTH(EJ_DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .RST(RST), .position(position), .bus(bus),
    .credit_cnt(credit_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .credit_err(credit_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs;
    bus.pe_valid    = 1'b0;
    bus.pe_dest     = '0;
    bus.pe_payload  = '0;
    bus.credit      = 1'b0;
    bus.eject_valid = 1'b0;
    bus.eject       = '0;
    bus.rx_ready    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk({tag, "_pe_ready"},     bus.pe_ready, 0);
    chk({tag, "_inject_valid"}, bus.inject_valid, 0);
    chk({tag, "_inject"},       bus.inject, 0);
    chk({tag, "_credit_cnt"},   credit_cnt, CREDITS);
    chk({tag, "_rx_valid"},     bus.rx_valid, 0);
    chk({tag, "_rx_data"},      bus.rx_data, 0);
    chk({tag, "_drop_cnt"},     drop_cnt, 0);
    chk({tag, "_overflow"},     overflow, 0);
    chk({tag, "_credit_err"},   credit_err, 0);
    RST = 1'b0;
    #1;
    chk({tag, "_pe_ready_rel"}, bus.pe_ready, 1);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic             pv;
    logic [PAY_W-1:0] pay;
    logic             cr;
    logic             e_iv;
    logic [FLIT_W-1:0] e_inj;
    logic [CNT_W-1:0] e_cc;
    logic             e_pr;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic set_vec(input int i, input logic pv, input int pay, input logic cr,
                         input logic e_iv, input int e_inj, input int e_cc, input logic e_pr);
    vecs[i].pv    = pv;
    vecs[i].pay   = PAY_W'(pay);
    vecs[i].cr    = cr;
    vecs[i].e_iv  = e_iv;
    vecs[i].e_inj = FLIT_W'(e_inj);
    vecs[i].e_cc  = CNT_W'(e_cc);
    vecs[i].e_pr  = e_pr;
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [FLIT_W-1:0] inj_exp [$];
  logic [FLIT_W-1:0] ej_exp [$];
  int pending_credits, sends, credits_given, drops;

  task automatic model_clear;
    inj_exp.delete();
    ej_exp.delete();
    pending_credits = 0;
    sends = 0;
    credits_given = 0;
    drops = 0;
  endtask

  // One random cycle: compare visible outputs with the model, pick inputs,
  // advance the model by what those inputs must do, then clock.
  task automatic rnd_cycle(input int pv_rate, input int cr_rate, input int ev_rate, input int rr_rate);
    logic exp_pr;
    logic [FLIT_W-1:0] f;
    if (bus.inject_valid) begin
      if (inj_exp.size() == 0) begin
        chk("rnd_inject_unexpected", 1, 0);
      end else begin
        f = inj_exp.pop_front();
        chk("rnd_inject", bus.inject, f);
      end
      sends++;
      pending_credits++;
    end
    chk("rnd_credit_cnt", credit_cnt, 32'(CREDITS - sends + credits_given));
    exp_pr = (inj_exp.size() < INJ_DEPTH);
    chk("rnd_pe_ready", bus.pe_ready, exp_pr);
    chk("rnd_rx_valid", bus.rx_valid, ej_exp.size() != 0);
    chk("rnd_drop_cnt", drop_cnt, (drops > 255) ? 255 : drops);
    chk("rnd_overflow", overflow, drops > 0);
    chk("rnd_credit_err", credit_err, 0);

    bus.pe_valid    = ($urandom_range(0, 99) < pv_rate);
    bus.pe_dest     = POS_W'($urandom);
    bus.pe_payload  = PAY_W'($urandom);
    if ($urandom_range(0, 9) == 0) position = POS_W'($urandom);
    bus.credit      = (pending_credits > 0) && ($urandom_range(0, 99) < cr_rate);
    bus.eject_valid = ($urandom_range(0, 99) < ev_rate);
    bus.eject       = FLIT_W'($urandom);
    bus.rx_ready    = ($urandom_range(0, 99) < rr_rate);

    if (bus.pe_valid && exp_pr) inj_exp.push_back({bus.pe_dest, position, bus.pe_payload});
    if (bus.credit) begin
      pending_credits--;
      credits_given++;
    end
    if (bus.rx_ready && ej_exp.size() > 0) begin
      f = ej_exp.pop_front();
      chk("rnd_rx_data", bus.rx_data, f);
    end
    if (bus.eject_valid) begin
      if (ej_exp.size() < EJ_DEPTH) ej_exp.push_back(bus.eject);
      else drops++;
    end
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [FLIT_W-1:0] ej_order [4];
    idle_inputs();
    do_reset("reset");

    // Six back-to-back pushes with 4 credits, two delayed credits, then a
    // full injection FIFO released by a single credit.
    set_vec( 0, 1, 'h0,  0, 0, 'h00000, 4, 1);
    set_vec( 1, 1, 'h1,  0, 1, 'h39000, 3, 1);
    set_vec( 2, 1, 'h2,  0, 1, 'h39001, 2, 1);
    set_vec( 3, 1, 'h3,  0, 1, 'h39002, 1, 1);
    set_vec( 4, 1, 'h4,  0, 1, 'h39003, 0, 1);
    set_vec( 5, 1, 'h5,  0, 0, 'h39003, 0, 1);
    set_vec( 6, 0, 'h0,  0, 0, 'h39003, 0, 1);
    set_vec( 7, 0, 'h0,  1, 0, 'h39003, 1, 1);
    set_vec( 8, 0, 'h0,  0, 1, 'h39004, 0, 1);
    set_vec( 9, 0, 'h0,  0, 0, 'h39004, 0, 1);
    set_vec(10, 0, 'h0,  1, 0, 'h39004, 1, 1);
    set_vec(11, 0, 'h0,  0, 1, 'h39005, 0, 1);
    set_vec(12, 0, 'h0,  0, 0, 'h39005, 0, 1);
    set_vec(13, 1, 'h6,  0, 0, 'h39005, 0, 1);
    set_vec(14, 1, 'h7,  0, 0, 'h39005, 0, 1);
    set_vec(15, 1, 'h8,  0, 0, 'h39005, 0, 1);
    set_vec(16, 1, 'h9,  0, 0, 'h39005, 0, 0);
    set_vec(17, 1, 'hAA, 0, 0, 'h39005, 0, 0);
    set_vec(18, 1, 'hAB, 1, 0, 'h39005, 1, 0);
    set_vec(19, 1, 'hAC, 0, 1, 'h39006, 0, 1);
    set_vec(20, 0, 'h0,  1, 0, 'h39006, 1, 1);
    set_vec(21, 0, 'h0,  1, 1, 'h39007, 1, 1);
    set_vec(22, 0, 'h0,  1, 1, 'h39008, 1, 1);
    set_vec(23, 0, 'h0,  0, 1, 'h39009, 0, 1);
    set_vec(24, 0, 'h0,  0, 0, 'h39009, 0, 1);
    set_vec(25, 0, 'h0,  1, 0, 'h39009, 1, 1);

    position    = 4'h9;
    bus.pe_dest = 4'h3;
    for (int i = 0; i < NVEC; i++) begin
      bus.pe_valid   = vecs[i].pv;
      bus.pe_payload = vecs[i].pay;
      bus.credit     = vecs[i].cr;
      tick();
      chk($sformatf("vec%0d_inject_valid", i), bus.inject_valid, vecs[i].e_iv);
      chk($sformatf("vec%0d_inject", i),       bus.inject, vecs[i].e_inj);
      chk($sformatf("vec%0d_credit_cnt", i),   credit_cnt, vecs[i].e_cc);
      chk($sformatf("vec%0d_pe_ready", i),     bus.pe_ready, vecs[i].e_pr);
    end
    idle_inputs();

    // Ejection overflow: six flits into a 4-deep FIFO nobody drains.
    chk("ej_idle_rx_valid", bus.rx_valid, 0);
    for (int k = 0; k < 6; k++) begin
      bus.eject_valid = 1'b1;
      bus.eject       = FLIT_W'(20'hE0000 + k);
      tick();
      if (k == 0) begin
        chk("ej_latency_rx_valid", bus.rx_valid, 1);
        chk("ej_latency_rx_data", bus.rx_data, 20'hE0000);
      end
    end
    bus.eject_valid = 1'b0;
    chk("ej_ovf_drop_cnt", drop_cnt, 2);
    chk("ej_ovf_overflow", overflow, 1);
    chk("ej_ovf_head", bus.rx_data, 20'hE0000);
    // Full FIFO with simultaneous push and pop keeps the new flit.
    bus.eject_valid = 1'b1;
    bus.eject       = 20'hE0006;
    bus.rx_ready    = 1'b1;
    tick();
    bus.eject_valid = 1'b0;
    chk("ej_pushpop_drop_cnt", drop_cnt, 2);
    ej_order[0] = 20'hE0001;
    ej_order[1] = 20'hE0002;
    ej_order[2] = 20'hE0003;
    ej_order[3] = 20'hE0006;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ej_drain%0d_rx_valid", k), bus.rx_valid, 1);
      chk($sformatf("ej_drain%0d_rx_data", k), bus.rx_data, ej_order[k]);
      tick();
    end
    bus.rx_ready = 1'b0;
    chk("ej_drained_rx_valid", bus.rx_valid, 0);
    chk("ej_drained_overflow_sticky", overflow, 1);

    // Credit error: fill up to CREDITS, then one extra pulse.
    for (int k = 0; k < 3; k++) begin
      bus.credit = 1'b1;
      tick();
    end
    chk("cerr_full_cnt", credit_cnt, CREDITS);
    chk("cerr_before", credit_err, 0);
    tick();
    bus.credit = 1'b0;
    chk("cerr_set", credit_err, 1);
    chk("cerr_cnt_sat", credit_cnt, CREDITS);
    tick();
    chk("cerr_sticky", credit_err, 1);

    // Mid-operation reset with both FIFOs partly full.
    bus.pe_dest = 4'h5;
    for (int k = 0; k < 6; k++) begin
      bus.pe_valid   = 1'b1;
      bus.pe_payload = PAY_W'(12'h100 + k);
      tick();
    end
    bus.pe_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.eject_valid = 1'b1;
      bus.eject       = FLIT_W'(20'hC0000 + k);
      tick();
    end
    chk("prerst_credit_cnt", credit_cnt, 0);
    chk("prerst_rx_valid", bus.rx_valid, 1);
    RST             = 1'b1;
    bus.pe_valid    = 1'b1;
    bus.credit      = 1'b1;
    bus.eject_valid = 1'b1;
    #1;
    chk("rst_pe_ready_masked", bus.pe_ready, 0);
    tick();
    idle_inputs();
    chk("midrst_rx_valid", bus.rx_valid, 0);
    chk("midrst_rx_data", bus.rx_data, 0);
    chk("midrst_inject_valid", bus.inject_valid, 0);
    chk("midrst_inject", bus.inject, 0);
    chk("midrst_credit_cnt", credit_cnt, CREDITS);
    chk("midrst_drop_cnt", drop_cnt, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_credit_err", credit_err, 0);
    RST = 1'b0;
    tick();
    chk("postrst_inject_valid", bus.inject_valid, 0);
    chk("postrst_rx_valid", bus.rx_valid, 0);
    chk("postrst_pe_ready", bus.pe_ready, 1);

    // Random traffic against queue models, congested then relaxed.
    do_reset("rnd_reset");
    model_clear();
    for (int c = 0; c < 1500; c++) rnd_cycle(70, 30, 60, 25);
    for (int c = 0; c < 1500; c++) rnd_cycle(50, 80, 40, 80);
    for (int c = 0; c < 200 && (inj_exp.size() != 0 || ej_exp.size() != 0 || pending_credits != 0); c++)
      rnd_cycle(0, 100, 0, 100);
    chk("drain_inj_empty", inj_exp.size(), 0);
    chk("drain_ej_empty", ej_exp.size(), 0);
    chk("drain_credits_home", credit_cnt, CREDITS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
